// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if : upstream issue and ALU-side handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_operand_stage_if #(
    parameter int WIDTH = 64,
    parameter int RD_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_alu_op;
    logic [2:0]       in_funct3;
    logic             in_funct7b5;
    logic             in_alu_src;
    logic [WIDTH-1:0] in_rs1_data;
    logic [WIDTH-1:0] in_rs2_data;
    logic [WIDTH-1:0] in_imm;
    logic [RD_W-1:0]  in_rd;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [3:0]       out_alu_op;
    logic [WIDTH-1:0] out_store_data;
    logic [RD_W-1:0]  out_rd;
    logic             out_illegal;

    modport master (
        output in_valid, in_alu_op, in_funct3, in_funct7b5, in_alu_src,
               in_rs1_data, in_rs2_data, in_imm, in_rd, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_op,
               out_store_data, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_alu_op, in_funct3, in_funct7b5, in_alu_src,
               in_rs1_data, in_rs2_data, in_imm, in_rd, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_op,
               out_store_data, out_rd, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage : registered ID/EX issue stage with 2-entry skid buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_operand_stage #(
    parameter int WIDTH = 64,
    parameter int RD_W  = 5
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          flush,
    alu_operand_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sd;
        logic [RD_W-1:0]  rd;
        logic [3:0]       op;
        logic             ill;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, new_entry;
    logic   in_ready_q, out_valid_q;
    logic   accept, drain;
    logic   load_main_in, load_main_skid, load_skid;

    always_comb begin
        new_entry     = '0;
        new_entry.a   = bus.in_rs1_data;
        new_entry.b   = bus.in_alu_src ? bus.in_imm : bus.in_rs2_data;
        new_entry.sd  = bus.in_rs2_data;
        new_entry.rd  = bus.in_rd;
        new_entry.op  = 4'b0000;
        new_entry.ill = 1'b0;
        case (bus.in_alu_op)
            2'b00: new_entry.op = 4'b0010;
            2'b01: new_entry.op = 4'b0110;
            2'b10: begin
                if (bus.in_funct3 == 3'b000)
                    new_entry.op = bus.in_funct7b5 ? 4'b0110 : 4'b0010;
                else if (bus.in_funct3 == 3'b111)
                    new_entry.op = 4'b0000;
                else if (bus.in_funct3 == 3'b110)
                    new_entry.op = 4'b0001;
                else if (bus.in_funct3 == 3'b100 && bus.in_funct7b5)
                    new_entry.op = 4'b1100;
                else
                    new_entry.ill = 1'b1;
            end
            default: new_entry.ill = 1'b1;
        endcase
    end

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = out_valid_q & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d      = S_ONE;
                        load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = S_TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (drain) begin
                        state_d        = S_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Handshake flags are flopped from the next state so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != S_TWO);
            out_valid_q <= (state_d != S_EMPTY);
            if (load_main_in)
                main_q <= new_entry;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= new_entry;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_a          = main_q.a;
    assign bus.out_b          = main_q.b;
    assign bus.out_store_data = main_q.sd;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_alu_op     = main_q.op;
    assign bus.out_illegal    = main_q.ill;
endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage : self-checking bench with a queue-based reference
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_operand_stage;
    localparam int WIDTH = 64;
    localparam int RD_W  = 5;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_operand_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

    alu_operand_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    localparam logic [63:0] RS1 = 64'h0000000AB000000F;
    localparam logic [63:0] RS2 = 64'h0002300000000F0F;

    // Expected ALU-side view of an operation, straight from the decode table.
    function automatic exp_t ref_entry(input logic [1:0] aop, input logic [2:0] f3,
                                       input logic f7, input logic src,
                                       input logic [63:0] rs1, input logic [63:0] rs2,
                                       input logic [63:0] imm, input logic [4:0] rd);
        exp_t e;
        e.a   = rs1;
        e.b   = src ? imm : rs2;
        e.sd  = rs2;
        e.rd  = rd;
        e.op  = 4'b0000;
        e.ill = 1'b0;
        if (aop == 2'd0)                          e.op = 4'b0010;
        else if (aop == 2'd1)                     e.op = 4'b0110;
        else if (aop == 2'd2 && f3 == 3'd0)       e.op = f7 ? 4'b0110 : 4'b0010;
        else if (aop == 2'd2 && f3 == 3'd7)       e.op = 4'b0000;
        else if (aop == 2'd2 && f3 == 3'd6)       e.op = 4'b0001;
        else if (aop == 2'd2 && f3 == 3'd4 && f7) e.op = 4'b1100;
        else                                      e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.a   = bus.out_a;
        o.b   = bus.out_b;
        o.sd  = bus.out_store_data;
        o.rd  = bus.out_rd;
        o.op  = bus.out_alu_op;
        o.ill = bus.out_illegal;
        return o;
    endfunction

    task automatic drive_op(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                            input logic src, input logic [63:0] rs1, input logic [63:0] rs2,
                            input logic [63:0] imm, input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_alu_op   = aop;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_alu_src  = src;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        bus.in_imm      = imm;
        bus.in_rd       = rd;
    endtask

    task automatic test_reset();
        exp_t o;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        drive_op(2'd2, 3'd0, 1'b0, 1'b0, RS1, RS2, 64'd0, 5'd0);
        bus.in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        o = observed();
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        else n_pass++;
        n_total++;
        if (o !== '0) $display("FAIL reset_outputs got=%h exp=0", o);
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [1:0] aops [9] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
        logic [2:0] f3s  [9] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd0, 3'd0, 3'd4, 3'd1};
        logic       f7s  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] ops  [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100,
                                 4'b0110, 4'b0000, 4'b0000, 4'b0000};
        logic       ills [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_op(aops[i], f3s[i], f7s[i], 1'b0, RS1, RS2, 64'h55, 5'(i));
            @(negedge clk);
            bus.in_valid = 1'b0;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_a !== RS1 || bus.out_b !== RS2)
                $display("FAIL decode%0d_operands valid=%b a=%h b=%h exp a=%h b=%h",
                         i, bus.out_valid, bus.out_a, bus.out_b, RS1, RS2);
            else n_pass++;
            n_total++;
            if (bus.out_alu_op !== ops[i] || bus.out_illegal !== ills[i])
                $display("FAIL decode%0d_op got op=%b ill=%b exp op=%b ill=%b",
                         i, bus.out_alu_op, bus.out_illegal, ops[i], ills[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_immediate();
        bus.out_ready = 1'b1;
        drive_op(2'd0, 3'd3, 1'b0, 1'b1, RS1, 64'h1234, 64'hFFFFFFFFFFFFFFF8, 5'd7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_b !== 64'hFFFFFFFFFFFFFFF8 || bus.out_store_data !== 64'h1234)
            $display("FAIL imm_select got b=%h sd=%h exp b=fffffffffffffff8 sd=1234",
                     bus.out_b, bus.out_store_data);
        else n_pass++;
        n_total++;
        if (bus.out_alu_op !== 4'b0010 || bus.out_illegal !== 1'b0 || bus.out_rd !== 5'd7)
            $display("FAIL imm_op got op=%b ill=%b rd=%0d exp op=0010 ill=0 rd=7",
                     bus.out_alu_op, bus.out_illegal, bus.out_rd);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_rd [3] = '{5'd1, 5'd2, 5'd3};
        bus.out_ready = 1'b0;
        drive_op(2'd0, 3'd0, 1'b0, 1'b0, RS1, RS2, 64'd0, 5'd1);
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after1 got=%b exp=1", bus.in_ready);
        else n_pass++;
        bus.in_rd = 5'd2;
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_after2 got=%b exp=0", bus.in_ready);
        else n_pass++;
        bus.in_rd = 5'd3;
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b0 || bus.out_rd !== 5'd1 || bus.out_valid !== 1'b1)
            $display("FAIL bp_hold got ready=%b rd=%0d valid=%b exp ready=0 rd=1 valid=1",
                     bus.in_ready, bus.out_rd, bus.out_valid);
        else n_pass++;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                n_total++;
                if (bus.out_valid !== 1'b1 || bus.out_rd !== exp_rd[i])
                    $display("FAIL bp_order%0d got valid=%b rd=%0d exp valid=1 rd=%0d",
                             i, bus.out_valid, bus.out_rd, exp_rd[i]);
                else n_pass++;
                if (i == 2) bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_drained got valid=%b exp=0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_total++;
            if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready%0d got=%b exp=1", i, bus.in_ready);
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'(i))
                    $display("FAIL b2b_out%0d got valid=%b rd=%0d exp valid=1 rd=%0d",
                             i, bus.out_valid, bus.out_rd, i);
                else n_pass++;
            end
            drive_op(2'd2, 3'd0, 1'b0, 1'b0, RS1 + 64'(i), RS2, 64'd0, 5'(i + 1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd8 || bus.out_a !== RS1 + 64'd7)
            $display("FAIL b2b_last got valid=%b rd=%0d a=%h exp valid=1 rd=8 a=%h",
                     bus.out_valid, bus.out_rd, bus.out_a, RS1 + 64'd7);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive_op(2'd0, 3'd0, 1'b0, 1'b0, RS1, RS2, 64'd0, 5'd10);
        @(negedge clk);
        bus.in_rd = 5'd11;
        @(negedge clk);
        bus.in_rd = 5'd12;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_two got valid=%b ready=%b exp valid=0 ready=1",
                     bus.out_valid, bus.in_ready);
        else n_pass++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_accept got valid=%b exp=0", bus.out_valid);
        else n_pass++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_stays_empty got valid=%b exp=0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic v, rdy, fl, acc, drn;
        flush = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            n_total++;
            if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2))
                $display("FAIL rand_flags cyc=%0d got valid=%b ready=%b exp valid=%b ready=%b",
                         cyc, bus.out_valid, bus.in_ready, q.size() > 0, q.size() < 2);
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if (observed() !== q[0])
                    $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, observed(), q[0]);
                else n_pass++;
            end
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            drive_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, 5'($urandom_range(0, 31)));
            bus.in_valid  = v;
            bus.out_ready = rdy;
            flush         = fl;
            if (fl) begin
                q.delete();
            end else begin
                acc = v && (q.size() < 2);
                drn = rdy && (q.size() > 0);
                if (drn) void'(q.pop_front());
                if (acc) begin
                    e = ref_entry(bus.in_alu_op, bus.in_funct3, bus.in_funct7b5, bus.in_alu_src,
                                  bus.in_rs1_data, bus.in_rs2_data, bus.in_imm, bus.in_rd);
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive_op(2'd2, 3'd7, 1'b0, 1'b1, RS1, RS2, 64'hABCD, 5'd20);
        @(negedge clk);
        bus.in_rd = 5'd21;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL async_flags got valid=%b ready=%b exp valid=0 ready=1",
                     bus.out_valid, bus.in_ready);
        else n_pass++;
        n_total++;
        if (observed() !== '0) $display("FAIL async_outputs got=%h exp=0", observed());
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL async_dropped got valid=%b exp=0", bus.out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_immediate();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered ID/EX issue stage directly upstream of the 64-bit ALU.
- Selects operand b (register or immediate), decodes main-control ALUOp plus funct fields into the ALU's 4-bit ALUOp, and presents a, b and ALUOp to the ALU.
- Decouples decode from execute with a valid/ready handshake and a 2-entry skid buffer, so the ALU side can stall without dropping or duplicating operations.

Parameters:
- WIDTH, 64, datapath width of rs1/rs2/imm/a/b.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- flush  input  1  synchronous; discards all held entries.
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  stage can accept; transfer when in_valid & in_ready.
- in_alu_op  input  2  main-control ALUOp: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- in_funct3  input  3  instruction funct3.
- in_funct7b5  input  1  instruction bit 30.
- in_alu_src  input  1  1: b = imm, 0: b = rs2.
- in_rs1_data  input  WIDTH  source operand 1.
- in_rs2_data  input  WIDTH  source operand 2.
- in_imm  input  WIDTH  sign-extended immediate.
- in_rd  input  RD_W  destination index.
- out_valid  output  1  ALU-side entry valid.
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
- out_a  output  WIDTH  ALU operand a.
- out_b  output  WIDTH  ALU operand b.
- out_alu_op  output  4  ALU operation code.
- out_store_data  output  WIDTH  rs2, carried for stores.
- out_rd  output  RD_W  destination index.
- out_illegal  output  1  decode produced no legal ALU operation.

Behaviour:
- Decode is combinational on the input side and is registered with the entry.
  - alu_op 00 -> 0010 (add).
  - alu_op 01 -> 0110 (sub).
  - alu_op 10, funct3 000: funct7b5=0 -> 0010, funct7b5=1 -> 0110.
  - alu_op 10, funct3 111 -> 0000 (and); funct3 110 -> 0001 (or); funct3 100 with funct7b5=1 -> 1100 (nor).
  - Anything else, including alu_op 11: out_alu_op=0000 and out_illegal=1.
  - Illegal entries still flow through the handshake; they are not dropped.
- Operand select: out_b = in_alu_src ? in_imm : in_rs2_data. out_a = in_rs1_data. All values are passed unmodified at full WIDTH; no arithmetic in this stage.
- Storage: main register (drives outputs) plus skid register. State machine:
  - EMPTY: out_valid=0, in_ready=1. On accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept with no drain: new entry goes to skid -> TWO.
    - Drain with no accept -> EMPTY.
    - Accept and drain together: new entry loads main, stays ONE.
  - TWO: out_valid=1, in_ready=0. On drain, skid moves to main -> ONE. in_valid is ignored.
- in_ready is a registered signal (equal to NOT skid-full), with no combinational path from out_ready.
- Latency: an accepted entry appears on outputs the cycle after acceptance when the stage was EMPTY, or when it was ONE with a same-cycle drain.
- Ordering: strict FIFO; no entry is lost or duplicated.
- flush: next state EMPTY; out_valid=0 and in_ready=1 next cycle. Any same-cycle accept is discarded. flush has priority over all handshakes.
- Reset (asynchronous, effective immediately):
  - State EMPTY, out_valid=0, in_ready=1.
  - out_a, out_b, out_store_data, out_rd, out_alu_op, out_illegal all 0.
  - Skid contents cleared.
  - Reset mid-transfer drops both entries.
- Outputs hold stable while out_valid=1 and out_ready=0.

Test Plan:
- R-type add: rs1=64'h0000000AB000000F, rs2=64'h0002300000000F0F, alu_op=10, funct3=000, funct7b5=0, out_ready=1 -> next cycle out_valid=1, out_a/out_b equal inputs, out_alu_op=0010, out_illegal=0.
- Decode sweep with the same operands:
  - sub (10/000/1) -> 0110.
  - and (10/111) -> 0000.
  - or (10/110) -> 0001.
  - nor (10/100/1) -> 1100.
  - alu_op=01 -> 0110.
  - alu_op=11 -> out_alu_op=0000, out_illegal=1.
- Immediate select: alu_op=00, alu_src=1, imm=64'hFFFFFFFFFFFFFFF8, rs2=64'h1234 -> out_b=64'hFFFFFFFFFFFFFFF8, out_store_data=64'h1234, out_alu_op=0010.
- Back-pressure: hold out_ready=0 and push 3 ops (rd=1,2,3).
  - in_ready drops after the 2nd accept; the 3rd is held upstream.
  - Release out_ready -> rd sequence 1,2,3 in order, with no gaps once flowing.
- Full-throughput: continuous in_valid and out_ready=1 for 8 ops -> one output per cycle and in_ready never deasserts.
- flush in TWO state -> next cycle out_valid=0 and in_ready=1; neither held entry appears. Async reset asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
